uart_tx16: RTL and testbench

UART_TX16 -- requirements
Module: uart_tx16

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick16.sv | 33 +++
 rtl/uart_tx16.sv | 148 ++++++++++++++
 tb/tb_uart_tx16.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame width, default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Transmit FSM states; the bit index is meaningful only in ST_DATA
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int DEF_CLKS_PER_TICK = 327;
  localparam int DEF_TICKS_PER_BIT = 16;

  // Divider width covers the largest legal CLKS_PER_TICK (511)
  localparam int TICK_DIV_W = 9;

endpackage

// File: rtl/baud_tick16.sv
// 16x-oversample tick divider: counts 0..CLKS_PER_TICK-1 and pulses tick at the terminal count.
// Latency: tick is combinational from the count; clear restarts the phase on the next edge.
// Backpressure: none, free-running unless clear is held.
module baud_tick16
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [TICK_DIV_W-1:0] DIV_LAST = TICK_DIV_W'(CLKS_PER_TICK - 1);

  logic [TICK_DIV_W-1:0] r_div;

  // tick is deliberately not gated by clear: the consumer derives clear from tick
  assign tick = (r_div == DIV_LAST);

  // Divider counter: restart on clear or after the terminal count
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (clear || tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx16.sv
// 8N1 UART transmitter with a one-byte holding register and 16x-oversample bit timing.
// Latency: handshake on edge E gives the start bit (txd = 0) after edge E+1.
// Backpressure: tx_ready low while the holding register is full; valid without ready is ignored.
module uart_tx16
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic       r_txd;
  logic       w_txd_nxt;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [3:0] r_tick_cnt;
  logic       w_tick;
  logic       w_clear;
  logic       w_bit_end;
  logic       w_frame_start;
  logic       w_hs;

  baud_tick16 #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (w_clear),
    .tick    (w_tick)
  );

  assign w_bit_end     = w_tick && (r_tick_cnt == TICK_LAST);
  assign w_hs          = tx_valid && !r_hold_full;
  // Entering START from anywhere else (IDLE or end of STOP) begins a new frame
  assign w_frame_start = (w_state_nxt == ST_START) && (r_state != ST_START);
  // Counters sit at zero in IDLE and restart on every frame so timing is relative to the start edge
  assign w_clear       = (r_state == ST_IDLE) || w_frame_start;

  // Tick counter: position within the current bit period
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_clear) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? 4'd0 : r_tick_cnt + 4'd1;
    end
  end

  // Holding register and shift register: accept on handshake, hand over at frame start
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
    end else if (w_frame_start) begin
      r_shift     <= r_hold;
      r_hold_full <= 1'b0;
    end else if (w_hs) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end
  end

  // FSM state register, including the registered serial output
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // FSM next-state: advance at the end of each bit period
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      ST_IDLE: begin
        w_bit_idx_nxt = '0;
        if (r_hold_full) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt   = ST_STOP;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        w_bit_idx_nxt = '0;
        if (w_bit_end) begin
          // A byte already waiting goes straight out with no idle gap
          w_state_nxt = r_hold_full ? ST_START : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  // FSM outputs: line level for the upcoming state, plus status flags
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = r_shift[w_bit_idx_nxt];
      default:  w_txd_nxt = 1'b1;
    endcase
    tx_ready = !r_hold_full;
    busy     = (r_state != ST_IDLE) || r_hold_full;
  end

  assign txd = r_txd;

endmodule

// File: tb/tb_uart_tx16.sv
// Self-checking bench for uart_tx16: directed steps plus a random back-to-back scoreboard.
// Three instances: fast-check (4 clk/tick, 64-cycle bits), default timing, and a minimal-bit-time one.
// Expected line levels come from the 8N1 frame rule and bit-time arithmetic.
module tb_uart_tx16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] v_rst;
  logic [2:0] v_valid;
  logic [7:0] v_data [3];
  wire  [2:0] v_ready;
  wire  [2:0] v_txd;
  wire  [2:0] v_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int BL [3] = '{64, 5232, 8};

  uart_tx16 #(.CLKS_PER_TICK(4), .TICKS_PER_BIT(16)) u_main (
    .CLOCK_50(clk), .reset(v_rst[0]), .tx_data(v_data[0]), .tx_valid(v_valid[0]),
    .tx_ready(v_ready[0]), .txd(v_txd[0]), .busy(v_busy[0]));

  uart_tx16 u_dflt (
    .CLOCK_50(clk), .reset(v_rst[1]), .tx_data(v_data[1]), .tx_valid(v_valid[1]),
    .tx_ready(v_ready[1]), .txd(v_txd[1]), .busy(v_busy[1]));

  uart_tx16 #(.CLKS_PER_TICK(2), .TICKS_PER_BIT(4)) u_fast (
    .CLOCK_50(clk), .reset(v_rst[2]), .tx_data(v_data[2]), .tx_valid(v_valid[2]),
    .tx_ready(v_ready[2]), .txd(v_txd[2]), .busy(v_busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following posedge number c
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offer a byte; hs returns the edge number on which it was accepted
  task automatic send(input int s, input logic [7:0] b, input bit keep, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    v_data[s]  = b;
    v_valid[s] = 1'b1;
    while (!v_ready[s] && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (!v_ready[s]) chk($sformatf("i%0d_send_ready_timeout", s), 32'(v_ready[s]), 32'd1);
    hs = cyc + 1;
    @(negedge clk);
    if (!keep) v_valid[s] = 1'b0;
  endtask

  // 8N1 reference: bit k of the frame occupies cycles [start+k*L, start+(k+1)*L)
  task automatic check_frame(input int s, input logic [7:0] b, input int start);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wait_until(start + k * BL[s]);
      chk($sformatf("i%0d_%02h_bit%0d_first", s, b, k), 32'(v_txd[s]), 32'(fr[k]));
      wait_until(start + (k + 1) * BL[s] - 1);
      chk($sformatf("i%0d_%02h_bit%0d_last", s, b, k), 32'(v_txd[s]), 32'(fr[k]));
    end
  endtask

  initial begin
    int hs;
    int hs2;
    int st;
    int rel;
    logic [7:0] acc;
    logic [7:0] tmp;
    logic [7:0] sbq [$];

    v_rst   = 3'b111;
    v_valid = 3'b000;
    for (int i = 0; i < 3; i++) v_data[i] = 8'h00;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_rst_txd", i), 32'(v_txd[i]), 32'd1);
      chk($sformatf("i%0d_rst_busy", i), 32'(v_busy[i]), 32'd0);
      chk($sformatf("i%0d_rst_ready", i), 32'(v_ready[i]), 32'd1);
    end
    @(negedge clk);
    v_rst = 3'b000;
    @(negedge clk);

    // Single byte 0xA5: latency, bit timing, busy release
    send(0, 8'hA5, 1'b0, hs);
    chk("a5_txd_before_start", 32'(v_txd[0]), 32'd1);
    chk("a5_ready_after_hs", 32'(v_ready[0]), 32'd0);
    chk("a5_busy_after_hs", 32'(v_busy[0]), 32'd1);
    check_frame(0, 8'hA5, hs + 1);
    chk("a5_busy_last_stop", 32'(v_busy[0]), 32'd1);
    wait_until(hs + 1 + 10 * 64);
    chk("a5_busy_done", 32'(v_busy[0]), 32'd0);
    chk("a5_ready_done", 32'(v_ready[0]), 32'd1);

    // 0x00 then 0xFF held valid: accepted during START, frames back-to-back
    @(negedge clk);
    v_data[0]  = 8'h00;
    v_valid[0] = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    v_data[0] = 8'hFF;
    fork
      begin
        check_frame(0, 8'h00, hs + 1);
        check_frame(0, 8'hFF, hs + 1 + 10 * 64);
      end
      begin
        wait_until(hs + 1);
        chk("ff_ready_in_start", 32'(v_ready[0]), 32'd1);
        wait_until(hs + 2);
        chk("ff_accepted", 32'(v_ready[0]), 32'd0);
        v_valid[0] = 1'b0;
      end
    join
    wait_until(hs + 1 + 20 * 64);
    chk("ff_busy_done", 32'(v_busy[0]), 32'd0);

    // Valid held while not ready, data churning: only handshake-edge values go out
    @(negedge clk);
    v_data[0]  = 8'h12;
    v_valid[0] = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    acc = 8'h00;
    fork
      begin
        check_frame(0, 8'h12, hs + 1);
        check_frame(0, acc, hs + 1 + 10 * 64);
      end
      begin
        int n;
        n = 0;
        v_data[0] = 8'($urandom);
        while (!v_ready[0] && n < 100) begin
          @(negedge clk);
          v_data[0] = 8'($urandom);
          n++;
        end
        acc = v_data[0];
        @(negedge clk);
        v_valid[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
          v_data[0] = 8'($urandom);
          @(negedge clk);
        end
      end
    join
    wait_until(hs + 1 + 22 * 64);
    chk("churn_no_extra_busy", 32'(v_busy[0]), 32'd0);
    chk("churn_no_extra_txd", 32'(v_txd[0]), 32'd1);

    // Reset in DATA bit 3 with a byte pending: abort and discard
    send(0, 8'h96, 1'b0, hs);
    st = hs + 1;
    send(0, 8'h41, 1'b0, hs2);
    wait_until(st + 4 * 64 + 32);
    tmp = 8'h96;
    chk("abort_pre_txd", 32'(v_txd[0]), 32'(tmp[3]));
    chk("abort_pre_busy", 32'(v_busy[0]), 32'd1);
    chk("abort_pre_ready", 32'(v_ready[0]), 32'd0);
    v_rst[0] = 1'b1;
    #1;
    chk("abort_txd_async", 32'(v_txd[0]), 32'd1);
    chk("abort_busy_async", 32'(v_busy[0]), 32'd0);
    chk("abort_ready_async", 32'(v_ready[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    v_rst[0] = 1'b0;
    rel = cyc;
    wait_until(rel + 200);
    chk("abort_no_resume_txd", 32'(v_txd[0]), 32'd1);
    chk("abort_no_resume_busy", 32'(v_busy[0]), 32'd0);
    send(0, 8'h3C, 1'b0, hs);
    chk("post_rst_txd_before_start", 32'(v_txd[0]), 32'd1);
    check_frame(0, 8'h3C, hs + 1);
    wait_until(hs + 1 + 10 * 64);
    chk("post_rst_busy_done", 32'(v_busy[0]), 32'd0);

    // Default timing: 5232-cycle bits, 52320-cycle frame
    send(1, 8'h55, 1'b0, hs);
    check_frame(1, 8'h55, hs + 1);
    chk("dflt_busy_last_cycle", 32'(v_busy[1]), 32'd1);
    wait_until(hs + 1 + 52320);
    chk("dflt_busy_done", 32'(v_busy[1]), 32'd0);

    // Scoreboard: mid-bit receiver on 256 random back-to-back bytes
    fork
      begin
        int hs_t;
        for (int i = 0; i < 256; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          sbq.push_back(b);
          send(2, b, 1'b0, hs_t);
        end
      end
      begin
        int prev_st;
        int s0;
        int n;
        logic [7:0] r;
        logic [7:0] e;
        prev_st = -1;
        for (int i = 0; i < 256; i++) begin
          n = 0;
          while (v_txd[2] !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
          end
          if (v_txd[2] !== 1'b0) begin
            chk($sformatf("sb%0d_start_timeout", i), 32'(v_txd[2]), 32'd0);
            break;
          end
          s0 = cyc;
          if (prev_st >= 0) chk($sformatf("sb%0d_gap", i), 32'(s0 - prev_st), 32'(10 * BL[2]));
          prev_st = s0;
          wait_until(s0 + BL[2] / 2);
          chk($sformatf("sb%0d_start_mid", i), 32'(v_txd[2]), 32'd0);
          r = 8'h00;
          for (int k = 0; k < 8; k++) begin
            wait_until(s0 + (k + 1) * BL[2] + BL[2] / 2);
            r[k] = v_txd[2];
          end
          wait_until(s0 + 9 * BL[2] + BL[2] / 2);
          chk($sformatf("sb%0d_stop_mid", i), 32'(v_txd[2]), 32'd1);
          e = (sbq.size() > 0) ? sbq.pop_front() : 8'hxx;
          chk($sformatf("sb%0d_byte", i), 32'(r), 32'(e));
        end
      end
    join
    wait_until(cyc + 2 * BL[2]);
    chk("sb_busy_done", 32'(v_busy[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
